// File: rtl/ei_axi4_wr_slave_mem.sv
// AXI4 write-path slave terminating AW/W/B into a byte-strobed memory.
// FIXED/INCR/WRAP bursts, narrow beats, sticky SLVERR, backdoor read port.
module ei_axi4_wr_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int WIDX      = $clog2(MEM_DEPTH)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [WIDX-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    localparam int LB = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  sup_q, sup_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] step, wrap_len, wrap_mask, wrap_base, addr_nxt;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic                  in_range, last_beat, w_hs, bad_aw, we;

    assign step      = ADDR_WIDTH'(1) << size_q;
    assign wrap_len  = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    assign wrap_mask = wrap_len - ADDR_WIDTH'(1);
    assign wrap_base = addr_q & ~wrap_mask;
    assign idx_full  = addr_q >> LB;
    assign in_range  = idx_full < ADDR_WIDTH'(MEM_DEPTH);
    assign last_beat = (beat_q == len_q);
    assign w_hs      = wvalid && wready;
    assign we        = (state == DATA) && w_hs && !sup_q && in_range;

    // Bursts the slave cannot honour are flagged and fully suppressed up front.
    assign bad_aw = (awburst == 2'b11) || (awsize > 3'(LB)) ||
                    ((awburst == 2'b10) &&
                     !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_comb begin
        addr_nxt = addr_q;
        unique case (burst_q)
            2'b01:   addr_nxt = addr_q + step;
            2'b10:   addr_nxt = wrap_base +
                                ((addr_q + step - wrap_base) & wrap_mask);
            default: addr_nxt = addr_q;
        endcase
    end

    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        sup_d   = sup_q;
        unique case (state)
            IDLE: begin
                if (awvalid && awready) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    beat_d  = 8'd0;
                    err_d   = bad_aw;
                    sup_d   = bad_aw;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (!in_range || (wlast != last_beat))
                        err_d = 1'b1;
                    addr_d = addr_nxt;
                    beat_d = beat_q + 8'd1;
                    if (last_beat)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (bvalid && bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            sup_q   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            sup_q   <= sup_d;
            // Outputs are registered from the next state.
            awready <= (state_d == IDLE);
            wready  <= (state_d == DATA);
            bvalid  <= (state_d == RESP);
            bresp   <= ((state_d == RESP) && err_d) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge aclk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b])
                    mem[idx_full[WIDX-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_ei_axi4_wr_slave_mem.sv
// Randomised scoreboard bench for ei_axi4_wr_slave_mem.
// Expected B responses are queued by the driver and checked by a monitor.
module tb_ei_axi4_wr_slave_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [9:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_rdata;

    ei_axi4_wr_slave_mem #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 aclk = ~aclk;

    int            checks = 0;
    int            failures = 0;
    logic [1:0]    exp_q[$];
    logic [DW-1:0] mdl[DEPTH];
    logic [DW-1:0] wd[256];
    logic [3:0]    ws[256];
    int            gap_max = 2;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_mem(input int idx);
        dbg_addr = 10'(idx);
        #1;
        chk($sformatf("mem[%0d]", idx), 64'(dbg_rdata), 64'(mdl[idx]));
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a,
            input int len, input int size, input int bt, input int i);
        longint unsigned st, bnd, av, base;
        st = 64'd1 << size;
        av = {32'd0, a};
        if (bt == 1)
            return 32'(av + longint'(i) * st);
        if (bt == 2) begin
            bnd  = longint'(len + 1) * st;
            base = av - (av % bnd);
            return 32'(base + (av - base + longint'(i) * st) % bnd);
        end
        return a;
    endfunction

    task automatic fill_rand(input int len, input bit full);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = full ? 4'hF : 4'($urandom);
        end
    endtask

    task automatic burst(input logic [31:0] a, input int len, input int size,
                         input int bt, input int badw, input int bdel);
        int         n;
        bit         err, sup;
        logic [31:0] ba;
        logic [1:0] eb;
        int         idx[256];
        sup = (bt == 3) || (size > 2) ||
              (bt == 2 && !(len inside {1, 3, 7, 15}));
        err = sup;
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr(a, len, size, bt, i);
            idx[i] = -1;
            if ((ba >> 2) >= DEPTH) begin
                err = 1'b1;
            end else begin
                idx[i] = int'(ba >> 2);
                if (!sup)
                    for (int b = 0; b < 4; b++)
                        if (ws[i][b]) mdl[idx[i]][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        if (badw >= 0 && badw <= len) err = 1'b1;
        eb = err ? 2'b10 : 2'b00;

        awaddr = a; awlen = 8'(len); awsize = 3'(size);
        awburst = 2'(bt); awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin tick(); n++; end
        if (!awready) begin
            chk("aw_timeout", 64'(awready), 64'd1);
            awvalid = 1'b0;
            return;
        end
        tick();
        awvalid = 1'b0;
        chk("wready_after_aw", 64'(wready), 64'd1);
        chk("awready_in_data", 64'(awready), 64'd0);

        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast = (i == len) ^ (i == badw);
            n = 0;
            while (!wready && n < 100) begin tick(); n++; end
            if (!wready) begin
                chk("w_timeout", 64'(wready), 64'd1);
                wvalid = 1'b0;
                return;
            end
            tick();
            wvalid = 1'b0; wlast = 1'b0;
        end
        exp_q.push_back(eb);
        chk("bvalid_after_last", 64'(bvalid), 64'd1);
        chk("wready_after_last", 64'(wready), 64'd0);
        repeat (bdel) begin
            tick();
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bresp_hold", 64'(bresp), 64'(eb));
            chk("awready_in_resp", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("awready_after_b", 64'(awready), 64'd1);
        chk("bvalid_after_b", 64'(bvalid), 64'd0);
        for (int i = 0; i <= len; i++)
            if (idx[i] >= 0) chk_mem(idx[i]);
    endtask

    initial begin : monitor
        forever begin
            @(negedge aclk);
            if (aresetn && bvalid && bready) begin
                if (exp_q.size() == 0)
                    chk("bresp_unexpected", 64'(bresp), 64'hx);
                else
                    chk("bresp", 64'(bresp), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a, len, size, bt, badw;
        #3;
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("awready_after_rst", 64'(awready), 64'd1);

        gap_max = 0;
        for (int k = 0; k < 4; k++) begin
            fill_rand(255, 1'b1);
            burst(32'(k * 1024), 255, 2, 1, -1, 0);
        end
        gap_max = 2;

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        burst(32'h10, 3, 2, 1, -1, 0);
        dbg_addr = 10'd5; #1;
        chk("incr_mem5", 64'(dbg_rdata), 64'h0000_00A1);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; end
        burst(32'h38, 3, 2, 2, -1, 0);
        dbg_addr = 10'd12; #1;
        chk("wrap_mem12", 64'(dbg_rdata), 64'h0000_00D2);

        wd[0] = 32'h11; ws[0] = 4'h1;
        wd[1] = 32'h2200; ws[1] = 4'h2;
        burst(32'h20, 1, 2, 0, -1, 0);
        dbg_addr = 10'd8; #1;
        chk("fixed_mem8_lo", 64'(dbg_rdata[15:0]), 64'h2211);

        fill_rand(0, 1'b1);
        burst(32'(DEPTH * 4), 0, 2, 1, -1, 0);
        fill_rand(3, 1'b1);
        burst(32'h200, 3, 2, 1, 1, 0);
        fill_rand(3, 1'b1);
        burst(32'h300, 3, 2, 1, -1, 5);
        fill_rand(3, 1'b0);
        burst(32'hFFFF_FFF8, 3, 2, 1, -1, 1);
        fill_rand(3, 1'b1);
        burst(32'(DEPTH * 4 - 8), 3, 2, 1, -1, 0);

        awaddr = 32'h100; awlen = 8'd3; awsize = 3'd2;
        awburst = 2'b01; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'hF; wlast = 1'b0;
        tick();
        wvalid = 1'b0;
        mdl[64] = 32'hCAFE_0001;
        aresetn = 1'b0;
        #1;
        chk("rst_mid_awready", 64'(awready), 64'd0);
        chk("rst_mid_wready", 64'(wready), 64'd0);
        chk("rst_mid_bvalid", 64'(bvalid), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("awready_after_rst2", 64'(awready), 64'd1);
        chk_mem(64);
        fill_rand(3, 1'b1);
        burst(32'h100, 3, 2, 1, -1, 0);

        for (int r = 0; r < 60; r++) begin
            bt = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            if (bt == 2 && $urandom_range(0, 5) != 0)
                len = (2 << $urandom_range(0, 3)) - 1;
            else
                len = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0)
                a = DEPTH * 4 - 16 + $urandom_range(0, 15);
            else
                a = $urandom_range(0, DEPTH * 4 - 1);
            badw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            fill_rand(len, 1'b0);
            burst(32'(a), len, size, bt, badw, $urandom_range(0, 3));
        end

        for (int i = 0; i < DEPTH; i++) chk_mem(i);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
